// File: rtl/debug_frame_sender.sv
// Byte serialiser for the debugger unit: snapshots the pipeline debug bus on a
// start request and streams it to the UART TX core as [header] payload [xor].
module debug_frame_sender #(
    parameter int         DATA_BYTES    = 324,
    parameter bit         SEND_HEADER   = 1'b1,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter bit         SEND_CHECKSUM = 1'b1,
    parameter bit         MSB_FIRST     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_BYTES*8-1:0] i_data_from_pipe,
    input  logic                    is_start,
    input  logic                    is_tx_done,
    input  logic                    i_abort,
    output logic [7:0]              o_tx_data,
    output logic                    os_tx_start,
    output logic                    os_done,
    output logic                    o_busy
);

    localparam int N     = int'(SEND_HEADER) + DATA_BYTES + int'(SEND_CHECKSUM);
    localparam int IDX_W = $clog2(N + 1);
    localparam int SEL_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                         state, state_nxt;
    logic [DATA_BYTES-1:0][7:0]     snapshot;
    logic [IDX_W-1:0]               index;
    logic [IDX_W-1:0]               pay_pos;
    logic [SEL_W-1:0]               byte_sel;
    logic [7:0]                     accum;
    logic [7:0]                     tx_data;
    logic [7:0]                     frame_byte;
    logic                           is_payload;
    logic                           last_byte;

    assign last_byte = (index == IDX_W'(N - 1));

    // Frame position -> byte: header first, then payload in the chosen order,
    // and whatever is left over is the running checksum.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        frame_byte = accum;
        is_payload = 1'b0;
        pay_pos    = index - IDX_W'(SEND_HEADER);
        byte_sel   = MSB_FIRST ? SEL_W'(DATA_BYTES - 1) - SEL_W'(pay_pos) : SEL_W'(pay_pos);
        if (SEND_HEADER && index == '0) begin
            frame_byte = HEADER_BYTE;
        end else if (pay_pos < IDX_W'(DATA_BYTES)) begin
            frame_byte = snapshot[byte_sel];
            is_payload = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (is_start && !i_abort) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (is_tx_done) state_nxt = last_byte ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (i_abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge value of every other register.
        if (rst) begin
            // NOTE: the snapshot is cleared too; a reset must not leak the
            // previous debug state into anything observable.
            state    <= S_IDLE;
            index    <= '0;
            accum    <= '0;
            snapshot <= '0;
            tx_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (is_start && !i_abort) begin
                    snapshot <= i_data_from_pipe;
                    index    <= '0;
                    accum    <= '0;
                end
                S_LOAD: if (!i_abort) begin
                    tx_data <= frame_byte;
                    if (is_payload) accum <= accum ^ frame_byte;
                end
                S_WAIT: if (is_tx_done && !i_abort && !last_byte) begin
                    index <= index + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data   = tx_data;
    assign os_tx_start = (state == S_ISSUE);
    assign os_done     = (state == S_DONE);
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_debug_frame_sender.sv
// Bench for debug_frame_sender: three 4-byte configurations share one stimulus
// stream and are each compared every cycle against a frame-level timing model.
module tb_debug_frame_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = '0;
    logic        is_start = 1'b0;
    logic        is_tx_done = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  tx_data [3];
    logic        tx_start [3];
    logic        done [3];
    logic        busy [3];

    always #5 clk = ~clk;

    debug_frame_sender #(.DATA_BYTES(4)) u_a (
        .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
        .is_tx_done(is_tx_done), .i_abort(i_abort), .o_tx_data(tx_data[0]),
        .os_tx_start(tx_start[0]), .os_done(done[0]), .o_busy(busy[0]));

    debug_frame_sender #(.DATA_BYTES(4), .MSB_FIRST(1'b1), .SEND_HEADER(1'b0)) u_b (
        .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
        .is_tx_done(is_tx_done), .i_abort(i_abort), .o_tx_data(tx_data[1]),
        .os_tx_start(tx_start[1]), .os_done(done[1]), .o_busy(busy[1]));

    debug_frame_sender #(.DATA_BYTES(4), .SEND_CHECKSUM(1'b0)) u_c (
        .clk(clk), .rst(rst), .i_data_from_pipe(data), .is_start(is_start),
        .is_tx_done(is_tx_done), .i_abort(i_abort), .o_tx_data(tx_data[2]),
        .os_tx_start(tx_start[2]), .os_done(done[2]), .o_busy(busy[2]));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Configuration of each instance, as plain numbers.
    int hdr [3] = '{1, 0, 1};
    int cks [3] = '{1, 1, 0};
    int msb [3] = '{0, 1, 0};

    function automatic int frame_len(input int i);
        return hdr[i] + 4 + cks[i];
    endfunction

    function automatic logic [7:0] frame_byte(input int i, input logic [31:0] d, input int pos);
        int p;
        p = pos - hdr[i];
        if (hdr[i] == 1 && pos == 0) return 8'hA5;
        if (p < 4) return d[8*(msb[i] == 1 ? 3 - p : p) +: 8];
        return d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

    // Frame model: a captured word, a byte position and the cycle numbers at
    // which the next launch / completion pulse are due.
    int          cyc = 0;
    bit          mv = 1'b0;
    bit          m_active [3] = '{0, 0, 0};
    bit          m_waiting [3] = '{0, 0, 0};
    logic [31:0] m_data [3];
    int          m_pos [3];
    int          m_issue [3] = '{-1, -1, -1};
    int          m_done [3] = '{-1, -1, -1};
    logic [7:0]  m_last [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0]  got [3][$];
    int          n_start [3] = '{0, 0, 0};
    int          n_done [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mv) begin
                if (cyc == m_issue[i]) m_last[i] = frame_byte(i, m_data[i], m_pos[i]);
                check($sformatf("busy[%0d] cyc %0d", i, cyc), 64'(busy[i]), 64'(m_active[i]));
                check($sformatf("tx_start[%0d] cyc %0d", i, cyc), 64'(tx_start[i]), 64'(cyc == m_issue[i]));
                check($sformatf("done[%0d] cyc %0d", i, cyc), 64'(done[i]), 64'(cyc == m_done[i]));
                check($sformatf("tx_data[%0d] cyc %0d", i, cyc), 64'(tx_data[i]), 64'(m_last[i]));
            end
            if (tx_start[i] === 1'b1) begin
                got[i].push_back(tx_data[i]);
                n_start[i]++;
            end
            if (done[i] === 1'b1) n_done[i]++;

            if (rst) begin
                m_active[i] = 0; m_waiting[i] = 0; m_issue[i] = -1; m_done[i] = -1; m_last[i] = 8'h00;
            end else if (m_active[i] && i_abort) begin
                m_active[i] = 0; m_waiting[i] = 0; m_issue[i] = -1; m_done[i] = -1;
            end else if (!m_active[i]) begin
                if (is_start && !i_abort) begin
                    m_active[i] = 1; m_waiting[i] = 0; m_data[i] = data;
                    m_pos[i] = 0; m_issue[i] = cyc + 2;
                end
            end else if (cyc == m_done[i]) begin
                m_active[i] = 0;
            end else if (cyc == m_issue[i]) begin
                m_waiting[i] = 1;
            end else if (m_waiting[i] && is_tx_done) begin
                m_waiting[i] = 0;
                if (m_pos[i] == frame_len(i) - 1) begin
                    m_done[i] = cyc + 1;
                end else begin
                    m_pos[i]++;
                    m_issue[i] = cyc + 2;
                end
            end
        end
        if (rst) mv = 1'b1;
        cyc++;
    end

    // UART stand-in: answers resp_delay cycles after any launch pulse.
    int cd = 0;
    int resp_delay = 5;
    bit spur = 1'b0;
    bit prev_done_drv = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        is_tx_done = 1'b0;
        if (rst) cd = 0;
        else if (tx_start[0] || tx_start[1] || tx_start[2]) cd = resp_delay;
        else if (cd > 0) begin
            cd--;
            if (cd == 0) is_tx_done = 1'b1;
        end
        if (spur && (tx_start[0] || prev_done_drv)) begin
            prev_done_drv = is_tx_done;
            is_tx_done = 1'b1;
        end else begin
            prev_done_drv = is_tx_done;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            step();
            t++;
        end while ((busy[0] || busy[1] || busy[2]) && t < 400);
        if (t >= 400) timeout_fail(name);
    endtask

    task automatic wait_starts(input int base, input int k, input string name);
        int t;
        t = 0;
        while (n_start[0] - base < k && t < 400) begin
            step();
            t++;
        end
        if (t >= 400) timeout_fail(name);
    endtask

    task automatic check_bytes(input string name, input int i, input int len, input logic [63:0] exp);
        logic [63:0] v;
        v = '0;
        foreach (got[i][k]) v = (v << 8) | 64'(got[i][k]);
        check({name, " count"}, 64'(got[i].size()), 64'(len));
        check({name, " bytes"}, v, exp);
    endtask

    task automatic clear_got();
        for (int i = 0; i < 3; i++) got[i].delete();
    endtask

    task automatic run_frame(input string name, input bit chg);
        int d0 [3];
        clear_got();
        for (int i = 0; i < 3; i++) d0[i] = n_done[i];
        data = 32'h44332211;
        is_start = 1'b1;
        step();
        is_start = 1'b0;
        if (chg) data = 32'hFFFFFFFF;
        wait_idle(name);
        check_bytes({name, " A"}, 0, 6, 64'hA5_11_22_33_44_44);
        check_bytes({name, " B"}, 1, 5, 64'h44_33_22_11_44);
        check_bytes({name, " C"}, 2, 5, 64'hA5_11_22_33_44);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s done count %0d", name, i), 64'(n_done[i] - d0[i]), 64'd1);
    endtask

    initial begin
        logic [63:0] v;
        int base, t, d0;

        // The model's own byte rules against hand-computed frames.
        for (int i = 0; i < 3; i++) begin
            v = '0;
            for (int p = 0; p < frame_len(i); p++) v = (v << 8) | 64'(frame_byte(i, 32'h44332211, p));
            check($sformatf("model frame %0d", i), v,
                  i == 0 ? 64'hA5_11_22_33_44_44 : (i == 1 ? 64'h44_33_22_11_44 : 64'hA5_11_22_33_44));
        end

        repeat (3) step();
        check("reset busy", 64'(busy[0]), 64'd0);
        check("reset tx_start", 64'(tx_start[0]), 64'd0);
        check("reset done", 64'(done[0]), 64'd0);
        check("reset tx_data", 64'(tx_data[0]), 64'd0);
        rst = 1'b0;
        step();

        // Basic frames; the second one changes the bus right after capture.
        run_frame("frame", 1'b0);
        run_frame("snapshot", 1'b1);

        // Abort coinciding with the UART completion of the second byte.
        clear_got();
        base = n_start[0];
        d0 = n_done[0];
        data = 32'h44332211;
        is_start = 1'b1;
        step();
        is_start = 1'b0;
        wait_starts(base, 2, "abort wait 2nd");
        t = 0;
        while (!is_tx_done && t < 50) begin step(); t++; end
        if (t >= 50) timeout_fail("abort wait done");
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check("abort busy A", 64'(busy[0]), 64'd0);
        check("abort busy B", 64'(busy[1]), 64'd0);
        repeat (12) step();
        check("abort no more starts", 64'(n_start[0] - base), 64'd2);
        check("abort no done", 64'(n_done[0] - d0), 64'd0);
        run_frame("after abort", 1'b0);

        // Start held high, stray completions in LOAD/ISSUE.
        clear_got();
        spur = 1'b1;
        data = 32'h44332211;
        is_start = 1'b1;
        t = 0;
        do begin step(); t++; end while (!done[0] && t < 400);
        if (t >= 400) timeout_fail("held start done");
        check_bytes("held start A", 0, 6, 64'hA5_11_22_33_44_44);
        t = 0;
        do begin step(); t++; end while (!tx_start[0] && t < 50);
        check("restart gap", 64'(t), 64'd3);
        is_start = 1'b0;
        spur = 1'b0;
        wait_idle("held start drain");

        // Reset during the wait for the third byte.
        base = n_start[0];
        d0 = n_done[0];
        is_start = 1'b1;
        step();
        is_start = 1'b0;
        wait_starts(base, 3, "reset wait 3rd");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", 64'(busy[0]), 64'd0);
        check("rst tx_start", 64'(tx_start[0]), 64'd0);
        check("rst tx_data", 64'(tx_data[0]), 64'd0);
        repeat (10) step();
        check("rst no done", 64'(n_done[0] - d0), 64'd0);
        run_frame("after reset", 1'b0);

        // Random traffic, checked cycle by cycle by the model.
        for (int n = 0; n < 4000; n++) begin
            resp_delay = int'($urandom_range(1, 8));
            step();
            data = $urandom;
            is_start = ($urandom_range(0, 3) == 0);
            i_abort = ($urandom_range(0, 63) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) is_tx_done = 1'b1;
        end
        is_start = 1'b0;
        i_abort = 1'b0;
        rst = 1'b0;
        resp_delay = 5;
        wait_idle("final drain");
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
